psg_multi_voice: RTL



---
 rtl/psg_multi_voice.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/psg_multi_voice.sv
`default_nettype none
// ============================================================================
// Module   : psg_multi_voice
// Purpose  : NUM_TONE square-wave voices plus one LFSR noise voice, each with
//            a 4-bit attenuator, mixed and delivered as a 1-bit PWM stream.
// Revision : 1.0
// ============================================================================
module psg_multi_voice #(
    parameter int NUM_TONE = 3,
    parameter int TONE_W   = 10,
    parameter int LFSR_W   = 16,
    parameter int TAP      = 3,
    parameter int CLK_DIV  = 16,
    parameter int PWM_W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       nWE,
    input  logic       nCE,
    input  logic [7:0] D,
    output logic       READY,
    output logic       AOUT
);
    localparam int SUM_W = 8 + $clog2(NUM_TONE + 1);
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [LFSR_W-1:0] LFSR_SEED = {1'b1, {(LFSR_W-1){1'b0}}};
    localparam logic [2:0]        NOISE_CH  = 3'd7;

    function automatic logic [7:0] amp_of(input logic [3:0] att);
        case (att)
            4'd0:    amp_of = 8'd255;
            4'd1:    amp_of = 8'd203;
            4'd2:    amp_of = 8'd161;
            4'd3:    amp_of = 8'd128;
            4'd4:    amp_of = 8'd102;
            4'd5:    amp_of = 8'd81;
            4'd6:    amp_of = 8'd64;
            4'd7:    amp_of = 8'd51;
            4'd8:    amp_of = 8'd40;
            4'd9:    amp_of = 8'd32;
            4'd10:   amp_of = 8'd26;
            4'd11:   amp_of = 8'd20;
            4'd12:   amp_of = 8'd16;
            4'd13:   amp_of = 8'd13;
            4'd14:   amp_of = 8'd10;
            default: amp_of = 8'd0;
        endcase
    endfunction

    logic              wr_q, wr_d, wr_dly_q, wr_dly_d;
    logic [7:0]        d_q, d_d;
    logic              ready_q, ready_d;
    logic [2:0]        addr_ch_q, addr_ch_d;
    logic              addr_att_q, addr_att_d;
    logic              ptr_q, ptr_d;
    logic [3:0]        att_q [NUM_TONE+1];
    logic [3:0]        att_d [NUM_TONE+1];
    logic [TONE_W-1:0] tone_q [NUM_TONE];
    logic [TONE_W-1:0] tone_d [NUM_TONE];
    logic [TONE_W-1:0] tcnt_q [NUM_TONE];
    logic [TONE_W-1:0] tcnt_d [NUM_TONE];
    logic [NUM_TONE-1:0] tout_q, tout_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [TONE_W-1:0] ncnt_q, ncnt_d;
    logic              nclk_q, nclk_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0]  level_q, level_d;
    logic              aout_q, aout_d;

    logic              w_accept, w_tick, w_fb;
    logic [TONE_W-1:0] w_nper;
    logic [SUM_W-1:0]  w_sum;
    logic [PWM_W-1:0]  w_level_mix;

    always_comb begin
        wr_d       = ~nWE & ~nCE;
        wr_dly_d   = wr_q;
        d_d        = D;
        w_accept   = wr_q & ~wr_dly_q;
        ready_d    = ~w_accept;
        w_tick     = (pre_q == PRE_W'(CLK_DIV - 1));
        pre_d      = pre_q + PRE_W'(1);
        addr_ch_d  = addr_ch_q;
        addr_att_d = addr_att_q;
        ptr_d      = ptr_q;
        att_d      = att_q;
        tone_d     = tone_q;
        tcnt_d     = tcnt_q;
        tout_d     = tout_q;
        ctrl_d     = ctrl_q;
        ncnt_d     = ncnt_q;
        nclk_d     = nclk_q;
        lfsr_d     = lfsr_q;
        w_fb       = ctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[TAP]) : lfsr_q[0];

        case (ctrl_q[1:0])
            2'd0:    w_nper = TONE_W'(16);
            2'd1:    w_nper = TONE_W'(32);
            2'd2:    w_nper = TONE_W'(64);
            default: w_nper = tone_q[NUM_TONE-1];
        endcase

        if (w_tick) begin
            for (int i = 0; i < NUM_TONE; i++) begin
                if (tone_q[i] == '0) begin
                    tcnt_d[i] = '0;
                    tout_d[i] = 1'b1;
                end else if (tcnt_q[i] == '0) begin
                    tcnt_d[i] = tone_q[i] - TONE_W'(1);
                    tout_d[i] = ~tout_q[i];
                end else begin
                    tcnt_d[i] = tcnt_q[i] - TONE_W'(1);
                end
            end
            if (w_nper == '0) begin
                ncnt_d = '0;
            end else if (ncnt_q == '0) begin
                ncnt_d = w_nper - TONE_W'(1);
                nclk_d = ~nclk_q;
                // Shift only on the rising edge of the internal noise clock
                if (!nclk_q)
                    lfsr_d = (lfsr_q == '0) ? LFSR_SEED : {w_fb, lfsr_q[LFSR_W-1:1]};
            end else begin
                ncnt_d = ncnt_q - TONE_W'(1);
            end
        end

        // Register writes override the tick results for the same state
        if (w_accept) begin
            if (d_q[7]) begin
                addr_ch_d  = d_q[6:4];
                addr_att_d = d_q[3];
                ptr_d      = 1'b0;
            end else begin
                ptr_d = ~ptr_q;
                if (addr_att_q) begin
                    if (addr_ch_q == NOISE_CH)
                        att_d[NUM_TONE] = d_q[3:0];
                    for (int i = 0; i < NUM_TONE; i++)
                        if (addr_ch_q == 3'(i))
                            att_d[i] = d_q[3:0];
                end else if (addr_ch_q == NOISE_CH) begin
                    ctrl_d = d_q[2:0];
                    lfsr_d = LFSR_SEED;
                    ncnt_d = '0;
                end else begin
                    for (int i = 0; i < NUM_TONE; i++) begin
                        if (addr_ch_q == 3'(i)) begin
                            if (!ptr_q)
                                tone_d[i][6:0] = d_q[6:0];
                            else
                                tone_d[i][TONE_W-1:7] = d_q[TONE_W-8:0];
                        end
                    end
                end
            end
        end

        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        level_d   = (pwm_cnt_q == {PWM_W{1'b1}}) ? w_level_mix : level_q;
        aout_d    = (pwm_cnt_q < level_q);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_TONE; i++)
            if (tout_q[i])
                w_sum = w_sum + SUM_W'(amp_of(att_q[i]));
        if (lfsr_q[0])
            w_sum = w_sum + SUM_W'(amp_of(att_q[NUM_TONE]));
    end

    generate
        if (SUM_W > PWM_W) begin : g_level_shift
            assign w_level_mix = PWM_W'(w_sum >> (SUM_W - PWM_W));
        end else begin : g_level_pad
            assign w_level_mix = PWM_W'(w_sum);
        end
    endgenerate

    // wr resets high so a strobe already asserted at reset release is ignored
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_q       <= 1'b1;
            wr_dly_q   <= 1'b1;
            d_q        <= '0;
            ready_q    <= 1'b1;
            addr_ch_q  <= '0;
            addr_att_q <= 1'b0;
            ptr_q      <= 1'b0;
            for (int i = 0; i <= NUM_TONE; i++)
                att_q[i] <= 4'hF;
            for (int i = 0; i < NUM_TONE; i++) begin
                tone_q[i] <= '0;
                tcnt_q[i] <= '0;
            end
            tout_q     <= '0;
            ctrl_q     <= '0;
            ncnt_q     <= '0;
            nclk_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            pre_q      <= '0;
            pwm_cnt_q  <= '0;
            level_q    <= '0;
            aout_q     <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            wr_dly_q   <= wr_dly_d;
            d_q        <= d_d;
            ready_q    <= ready_d;
            addr_ch_q  <= addr_ch_d;
            addr_att_q <= addr_att_d;
            ptr_q      <= ptr_d;
            att_q      <= att_d;
            tone_q     <= tone_d;
            tcnt_q     <= tcnt_d;
            tout_q     <= tout_d;
            ctrl_q     <= ctrl_d;
            ncnt_q     <= ncnt_d;
            nclk_q     <= nclk_d;
            lfsr_q     <= lfsr_d;
            pre_q      <= pre_d;
            pwm_cnt_q  <= pwm_cnt_d;
            level_q    <= level_d;
            aout_q     <= aout_d;
        end
    end

    assign READY = ready_q;
    assign AOUT  = aout_q;

endmodule
`default_nettype wire
